// File: rtl/measure_report_tx.sv
// ---------------------------------------------------------------------------
// measure_report_tx
// Captures signed 12-bit max/min measurement pairs, derives peak-to-peak and
// midpoint, and serializes a 13-byte report packet onto a valid/ready byte
// stream. A one-deep pending buffer holds a result that arrives while a
// packet is in flight; later overwrites of that buffer are counted as drops.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_measure_max/min   signed window max/min, sampled on i_measure_vld
//   i_measure_vld       single-cycle result strobe
//   o_tx_data/valid     packet byte stream
//   o_tx_last           marks the checksum byte
//   i_tx_ready          downstream accept
//   o_busy              packet in progress or result pending
//   o_drop_cnt          saturating count of overwritten pending results
// ---------------------------------------------------------------------------
module measure_report_tx #(
    parameter logic [7:0] P_SYNC0 = 8'hA5,
    parameter logic [7:0] P_SYNC1 = 8'h5A,
    parameter logic [3:0] P_CH_ID = 4'h0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [11:0] i_measure_max,
    input  logic [11:0] i_measure_min,
    input  logic        i_measure_vld,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    output logic        o_tx_last,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic [15:0] o_drop_cnt
);

    localparam int unsigned MEAS_W   = 12;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned PKT_LEN  = 13;
    localparam int unsigned LAST_IDX = PKT_LEN - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND
    } state_t;

    state_t              state, state_d;
    logic [IDX_W-1:0]    idx, idx_d;
    logic [7:0]          seq, seq_d;

    logic [MEAS_W-1:0]   pend_max, pend_min;
    logic                pend_full, pend_full_d;
    logic                ovf, ovf_d;
    logic                load;
    logic                drop;
    logic [15:0]         drop_cnt_d;

    logic [MEAS_W-1:0]   w_max, w_min;
    logic [7:0]          w_status;
    logic [15:0]         w_vpp, w_mid;

    logic [7:0]          tx_data_d;
    logic                tx_valid_d, tx_last_d, busy_d;

    logic signed [12:0]  ld_max_s, ld_min_s, ld_diff, ld_sum, ld_half;
    logic                ld_invalid;
    logic [15:0]         ld_vpp, ld_mid;

    logic [7:0]          pkt [PKT_LEN];
    logic [7:0]          csum;

    // Derived fields from the pending pair, registered at LOAD
    always_comb begin
        ld_max_s   = {pend_max[MEAS_W-1], pend_max};
        ld_min_s   = {pend_min[MEAS_W-1], pend_min};
        ld_diff    = ld_max_s - ld_min_s;
        ld_sum     = ld_max_s + ld_min_s;
        ld_half    = ld_sum >>> 1;
        ld_invalid = ld_max_s < ld_min_s;
        ld_vpp     = ld_invalid ? 16'h0000 : {3'b000, ld_diff};
        ld_mid     = ld_invalid ? 16'h0000 : {{3{ld_half[12]}}, ld_half};
    end

    // Packet byte map built from the working registers
    always_comb begin
        pkt[0]  = P_SYNC0;
        pkt[1]  = P_SYNC1;
        pkt[2]  = seq;
        pkt[3]  = w_status;
        pkt[4]  = {{4{w_max[MEAS_W-1]}}, w_max[11:8]};
        pkt[5]  = w_max[7:0];
        pkt[6]  = {{4{w_min[MEAS_W-1]}}, w_min[11:8]};
        pkt[7]  = w_min[7:0];
        pkt[8]  = w_vpp[15:8];
        pkt[9]  = w_vpp[7:0];
        pkt[10] = w_mid[15:8];
        pkt[11] = w_mid[7:0];
        csum    = 8'h00;
        for (int k = 0; k < int'(LAST_IDX); k++) begin
            csum = csum + pkt[k];
        end
        pkt[12] = csum;
    end

    // Next-state, pending buffer and registered-output logic
    always_comb begin
        state_d    = state;
        idx_d      = idx;
        seq_d      = seq;
        tx_data_d  = o_tx_data;
        tx_valid_d = o_tx_valid;
        tx_last_d  = o_tx_last;
        load       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pend_full) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                load       = 1'b1;
                state_d    = ST_SEND;
                idx_d      = '0;
                tx_valid_d = 1'b1;
                tx_data_d  = P_SYNC0;
                tx_last_d  = 1'b0;
            end
            ST_SEND: begin
                if (o_tx_valid && i_tx_ready) begin
                    if (idx == IDX_W'(LAST_IDX)) begin
                        seq_d      = seq + 8'd1;
                        tx_valid_d = 1'b0;
                        tx_last_d  = 1'b0;
                        tx_data_d  = 8'h00;
                        state_d    = pend_full ? ST_LOAD : ST_IDLE;
                    end else begin
                        idx_d     = idx + IDX_W'(1);
                        tx_data_d = pkt[idx_d];
                        tx_last_d = (idx_d == IDX_W'(LAST_IDX));
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A strobe during LOAD refills the buffer that LOAD is draining
        drop        = i_measure_vld && pend_full && !load;
        pend_full_d = i_measure_vld ? 1'b1 : (load ? 1'b0 : pend_full);
        ovf_d       = (ovf && !load) || drop;
        drop_cnt_d  = (drop && (o_drop_cnt != 16'hFFFF)) ? o_drop_cnt + 16'd1 : o_drop_cnt;
        busy_d      = (state_d != ST_IDLE) || pend_full_d;
    end

    // State and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            seq        <= 8'h00;
            pend_max   <= '0;
            pend_min   <= '0;
            pend_full  <= 1'b0;
            ovf        <= 1'b0;
            w_max      <= '0;
            w_min      <= '0;
            w_status   <= 8'h00;
            w_vpp      <= 16'h0000;
            w_mid      <= 16'h0000;
            o_tx_data  <= 8'h00;
            o_tx_valid <= 1'b0;
            o_tx_last  <= 1'b0;
            o_busy     <= 1'b0;
            o_drop_cnt <= 16'h0000;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            seq        <= seq_d;
            pend_full  <= pend_full_d;
            ovf        <= ovf_d;
            o_tx_data  <= tx_data_d;
            o_tx_valid <= tx_valid_d;
            o_tx_last  <= tx_last_d;
            o_busy     <= busy_d;
            o_drop_cnt <= drop_cnt_d;
            if (i_measure_vld) begin
                pend_max <= i_measure_max;
                pend_min <= i_measure_min;
            end
            if (load) begin
                w_max    <= pend_max;
                w_min    <= pend_min;
                w_status <= {P_CH_ID, 2'b00, ovf, ld_invalid};
                w_vpp    <= ld_vpp;
                w_mid    <= ld_mid;
            end
        end
    end

endmodule

// File: tb/tb_measure_report_tx.sv
// ---------------------------------------------------------------------------
// tb_measure_report_tx
// Scoreboard bench: each packet the DUT should emit is built by a reference
// model and queued when the strobe is driven; a negedge monitor pops and
// compares every accepted byte, and checks stability under backpressure.
// ---------------------------------------------------------------------------
module tb_measure_report_tx;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [11:0] i_measure_max = '0;
    logic [11:0] i_measure_min = '0;
    logic        i_measure_vld = 1'b0;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        o_tx_last;
    logic        i_tx_ready = 1'b0;
    logic        o_busy;
    logic [15:0] o_drop_cnt;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [7:0]  exp_q [$];
    logic [7:0]  exp_seq = 8'h00;
    int          pos = 0;
    int          hs_total = 0;
    logic        stall_prev = 1'b0;
    logic [7:0]  held_data = '0;
    logic        held_last = 1'b0;

    measure_report_tx dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_measure_max (i_measure_max),
        .i_measure_min (i_measure_min),
        .i_measure_vld (i_measure_vld),
        .o_tx_data     (o_tx_data),
        .o_tx_valid    (o_tx_valid),
        .o_tx_last     (o_tx_last),
        .i_tx_ready    (i_tx_ready),
        .o_busy        (o_busy),
        .o_drop_cnt    (o_drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference packet builder using integer arithmetic
    function automatic void push_pkt(input logic [11:0] mx, input logic [11:0] mn,
                                     input logic [7:0] sq, input logic ovf);
        int         imx, imn, vpp, mid;
        logic       inv;
        logic [7:0] b [13];
        logic [7:0] cs;
        imx   = int'($signed(mx));
        imn   = int'($signed(mn));
        inv   = (imx < imn);
        vpp   = inv ? 0 : (imx - imn);
        mid   = inv ? 0 : ((imx + imn) >>> 1);
        b[0]  = 8'hA5;
        b[1]  = 8'h5A;
        b[2]  = sq;
        b[3]  = {4'h0, 2'b00, ovf, inv};
        b[4]  = 8'(imx >>> 8);
        b[5]  = 8'(imx);
        b[6]  = 8'(imn >>> 8);
        b[7]  = 8'(imn);
        b[8]  = 8'(vpp >>> 8);
        b[9]  = 8'(vpp);
        b[10] = 8'(mid >>> 8);
        b[11] = 8'(mid);
        cs    = 8'h00;
        for (int k = 0; k < 12; k++) cs = cs + b[k];
        b[12] = cs;
        for (int k = 0; k < 13; k++) exp_q.push_back(b[k]);
    endfunction

    // Byte monitor: handshakes on the following posedge are decided here
    always @(negedge i_clk) begin
        if (i_rst) begin
            pos        = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check_eq("hold_valid", 32'(o_tx_valid), 32'd1);
                check_eq("hold_data", 32'(o_tx_data), 32'(held_data));
                check_eq("hold_last", 32'(o_tx_last), 32'(held_last));
            end
            if (o_tx_valid && !i_tx_ready) begin
                stall_prev = 1'b1;
                held_data  = o_tx_data;
                held_last  = o_tx_last;
            end else begin
                stall_prev = 1'b0;
            end
            if (o_tx_valid && i_tx_ready) begin
                hs_total++;
                if (exp_q.size() == 0) begin
                    check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check_eq("pkt_byte", 32'(o_tx_data), 32'(e));
                    check_eq("pkt_last", 32'(o_tx_last), 32'(pos == 12));
                end
                pos = (pos == 12) ? 0 : pos + 1;
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse(input logic [11:0] mx, input logic [11:0] mn);
        i_measure_max = mx;
        i_measure_min = mn;
        i_measure_vld = 1'b1;
        tick();
        i_measure_vld = 1'b0;
    endtask

    task automatic send(input logic [11:0] mx, input logic [11:0] mn, input logic ovf);
        push_pkt(mx, mn, exp_seq, ovf);
        exp_seq = exp_seq + 8'd1;
        pulse(mx, mn);
    endtask

    task automatic wait_idle(input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge i_clk);
            if (exp_q.size() == 0 && !o_tx_valid && !o_busy) begin
                done = 1'b1;
                break;
            end
        end
        check_eq("idle_reached", 32'(done), 32'd1);
        tick();
    endtask

    task automatic wait_pos(input int p);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (o_tx_valid && pos == p) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check_eq("reach_pos", 32'(ok), 32'd1);
    endtask

    initial begin
        int hs_start;

        // Reset values
        repeat (2) @(negedge i_clk);
        check_eq("rst_data", 32'(o_tx_data), 32'h0);
        check_eq("rst_valid", 32'(o_tx_valid), 32'h0);
        check_eq("rst_last", 32'(o_tx_last), 32'h0);
        check_eq("rst_busy", 32'(o_busy), 32'h0);
        check_eq("rst_drop", 32'(o_drop_cnt), 32'h0);
        tick();
        i_rst = 1'b0;
        tick();

        // Basic packet and latency
        i_tx_ready = 1'b1;
        send(12'h3FF, 12'hC00, 1'b0);
        @(negedge i_clk);
        check_eq("lat_busy", 32'(o_busy), 32'd1);
        check_eq("lat_n0", 32'(o_tx_valid), 32'd0);
        @(negedge i_clk);
        check_eq("lat_n1", 32'(o_tx_valid), 32'd0);
        @(negedge i_clk);
        check_eq("lat_n2", 32'(o_tx_valid), 32'd1);
        check_eq("lat_byte0", 32'(o_tx_data), 32'hA5);
        wait_idle(100);

        // Empty window: invalid flag, zeroed vpp/mid, seq 01
        send(12'h800, 12'h7FF, 1'b0);
        wait_idle(100);
        check_eq("drop_zero", 32'(o_drop_cnt), 32'd0);

        // Stall three cycles on byte 5
        hs_start = hs_total;
        send(12'h123, 12'hF45, 1'b0);
        wait_pos(5);
        i_tx_ready = 1'b0;
        repeat (3) tick();
        i_tx_ready = 1'b1;
        wait_idle(100);
        check_eq("hs_count", 32'(hs_total - hs_start), 32'd13);

        // Random backpressure over a few packets
        for (int p = 0; p < 3; p++) begin
            send(12'($urandom), 12'($urandom), 1'b0);
            for (int c = 0; c < 400; c++) begin
                i_tx_ready = 1'($urandom_range(0, 1));
                tick();
                if (exp_q.size() == 0 && !o_tx_valid) break;
            end
            i_tx_ready = 1'b1;
            wait_idle(100);
        end

        // Pending absorb, overwrite and overflow flag
        i_tx_ready = 1'b0;
        send(12'h100, 12'h050, 1'b0);
        repeat (4) tick();
        check_eq("stalled_valid", 32'(o_tx_valid), 32'd1);
        pulse(12'h222, 12'h111);
        repeat (2) tick();
        push_pkt(12'h333, 12'hE00, exp_seq, 1'b1);
        exp_seq = exp_seq + 8'd1;
        pulse(12'h333, 12'hE00);
        tick();
        check_eq("drop_one", 32'(o_drop_cnt), 32'd1);
        check_eq("busy_stall", 32'(o_busy), 32'd1);
        i_tx_ready = 1'b1;
        wait_idle(200);
        send(12'h044, 12'h040, 1'b0);
        wait_idle(100);
        check_eq("drop_still_one", 32'(o_drop_cnt), 32'd1);

        // Sequence wrap across a full 256-packet cycle
        for (int p = 0; p < 256; p++) begin
            send(12'($urandom), 12'($urandom), 1'b0);
            wait_idle(100);
        end

        // Drop counter saturation
        i_tx_ready = 1'b0;
        send(12'h010, 12'h001, 1'b0);
        repeat (4) tick();
        i_measure_max = 12'h5A5;
        i_measure_min = 12'hA5A;
        i_measure_vld = 1'b1;
        repeat (65540) tick();
        i_measure_vld = 1'b0;
        push_pkt(12'h5A5, 12'hA5A, exp_seq, 1'b1);
        exp_seq = exp_seq + 8'd1;
        check_eq("drop_sat", 32'(o_drop_cnt), 32'hFFFF);
        i_tx_ready = 1'b1;
        wait_idle(200);
        check_eq("drop_sat_hold", 32'(o_drop_cnt), 32'hFFFF);

        // Reset in the middle of a packet
        send(12'h7FF, 12'h800, 1'b0);
        wait_pos(7);
        i_rst = 1'b1;
        exp_q.delete();
        exp_seq = 8'h00;
        @(negedge i_clk);
        check_eq("midrst_valid", 32'(o_tx_valid), 32'd0);
        check_eq("midrst_last", 32'(o_tx_last), 32'd0);
        check_eq("midrst_busy", 32'(o_busy), 32'd0);
        check_eq("midrst_drop", 32'(o_drop_cnt), 32'd0);
        repeat (2) tick();
        i_rst = 1'b0;
        tick();
        send(12'h0F0, 12'hF10, 1'b0);
        wait_idle(100);
        check_eq("post_rst_drop", 32'(o_drop_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
